onehot_req_serializer: RTL and testbench
========================================

Name: onehot_req_serializer

Overview:
- Upstream stage for the 8-to-3 encoder.
- Captures asynchronous-in-time request lines (switches, interrupt sources) as sticky pending events.
- Issues the events one at a time as a strictly one-hot vector with a valid/ready handshake, chosen round-robin, so the encoder never sees zero-hot-while-valid or multi-hot input.
- Guarantees the encoder's one-hot precondition by construction.

Parameters:
N, 8, number of request lines / width of one-hot output (power of two, 2..16)
EDGE, 1, 1 = rising-edge triggered events; 0 = level triggered (request re-arms while held)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req_in  input  N  raw request lines, already synchronous to clk
out_onehot  output  N  one-hot event code to encoder; all-zero when out_valid=0
out_valid  output  1  out_onehot holds a valid event
out_ready  input  1  consumer accepts event this cycle
pending  output  N  registered sticky pending-event mask (status)
overflow  output  1  one-cycle pulse: new event merged into an already-pending bit

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high (rst sampled on clk rising edge).
- Reset values: out_onehot=0, out_valid=0, pending=0, overflow=0, req_q=0, rr_ptr=0, FSM=IDLE.
- req_q=0 after reset: a line already high at the first post-reset cycle counts as an edge.
- Event detect (combinational):
  - EDGE=1: evt = req_in & ~req_q.
  - EDGE=0: evt = req_in.
  - req_q <= req_in every cycle.
- Handshake accept: acc = out_valid & out_ready.
- Load condition: load = pending!=0 & (IDLE | acc).
- sel = first set bit of pending searching index rr_ptr, rr_ptr+1, ..., N-1, then wrapping 0..rr_ptr-1.
- On load:
  - out_onehot <= (1<<sel)
  - pending[sel] cleared
  - rr_ptr <= (sel+1) mod N (wrap at N-1 -> 0)
- pending next = (pending & ~(load ? 1<<sel : 0)) | evt.
  - An event on the bit being loaded this cycle re-sets it; it is a new event, not overflow.
- overflow <= |(evt & pending & ~(load ? 1<<sel : 0)). The extra event is dropped (merged).
- Event on the bit currently shown on out_onehot (not pending): sets pending normally, no overflow.
- FSM IDLE:
  - pending!=0 -> load, out_valid<=1, go PRESENT.
  - Otherwise out_valid=0, out_onehot=0.
- FSM PRESENT:
  - out_ready=0: out_onehot and out_valid held stable. No change permitted while stalled.
  - acc with pending!=0: load next event the same edge, out_valid stays 1 (back-to-back, one event per cycle).
  - acc with pending=0: out_valid<=0, out_onehot<=0, go IDLE.
- Latency: edge sampled at clk edge k -> pending bit set after k -> out_valid=1 after edge k+1 (from IDLE).
- Throughput: 1 event/cycle with out_ready held high.
- Invariant: out_valid=1 implies $onehot(out_onehot); out_valid=0 implies out_onehot=0.
- EDGE=0: a held line re-enters pending the cycle after it is loaded, giving fair round-robin repetition. Overflow fires each cycle the held bit is still pending.
- rst mid-operation: all events, including the one presented, are discarded. Outputs return to reset values on the following edge.

Test Plan:
- Single event: reset, then req_in=0x04 held, out_ready=1 -> pending=0x04 one cycle later; out_valid=1, out_onehot=0x04 for exactly one cycle; then idle, no repeat (EDGE=1).
- Simultaneous: req_in 0x00->0x81, rr_ptr=0, out_ready=1 -> out_onehot 0x01 then 0x80 on consecutive cycles; out_valid high 2 cycles; rr_ptr ends 0.
- Round-robin wrap: grant bit 3 (rr_ptr=4), then events on bits 1 and 3 together -> next out_onehot=0x02, then 0x08.
- Backpressure:
  - Stimulus: event 0x10 with out_ready=0 for 5 cycles, meanwhile event 0x02.
  - Response: out_onehot stays 0x10 all 5 cycles; pending=0x02.
  - On the ready cycle: 0x02 follows next cycle.
- Overflow:
  - Stimulus: out_ready=0 while presenting 0x01; pulse bit 5 twice (0->1->0->1).
  - Response: overflow pulses once on the second edge; after release exactly one 0x20 is delivered.
- Reset mid-op: pending=0x66, presenting 0x02, assert rst one cycle -> next cycle out_valid=0, out_onehot=0, pending=0, rr_ptr=0. With req_in held at 0x40 through reset, a 0x40 event is delivered 2 cycles after rst deasserts.

Source files
------------

// File: rtl/onehot_req_serializer.sv
`default_nettype none
// ============================================================================
// onehot_req_serializer -- captures request lines as sticky pending events and
// issues them one at a time, round-robin, as a strictly one-hot valid/ready code.
// Revision: 1.0
// ============================================================================
module onehot_req_serializer #(
  parameter int N    = 8,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  req_q;
  logic [N-1:0]  evt;
  logic [N-1:0]  grant;
  logic [N-1:0]  sel_mask;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;
  logic          found;
  logic          acc;
  logic          load;

  generate
    if (EDGE) begin : g_edge
      assign evt = req_in & ~req_q;
    end else begin : g_level
      logic unused_req_q;
      assign unused_req_q = ^req_q;
      assign evt          = req_in;
    end
  endgenerate

  // Search starts at rr_ptr; N is a power of two so index wrap is free truncation.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr_ptr + PW'(i);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign grant    = {{(N-1){1'b0}}, 1'b1} << sel;
  assign acc      = out_valid & out_ready;
  assign load     = found & ((state == IDLE) | acc);
  assign sel_mask = load ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      rr_ptr     <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else begin
      req_q    <= req_in;
      // A fresh event on the bit being loaded re-arms it rather than overflowing.
      pending  <= (pending & ~sel_mask) | evt;
      overflow <= |(evt & pending & ~sel_mask);
      case (state)
        IDLE: begin
          if (load) begin
            out_onehot <= grant;
            out_valid  <= 1'b1;
            rr_ptr     <= sel + 1'b1;
            state      <= PRESENT;
          end else begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
          end
        end
        PRESENT: begin
          if (load) begin
            out_onehot <= grant;
            rr_ptr     <= sel + 1'b1;
          end else if (acc) begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_req_serializer.sv
`default_nettype none
// Testbench for onehot_req_serializer: directed scenarios followed by random
// traffic, all checked against an index-based event-queue reference model.
module tb_onehot_req_serializer;

  localparam int N    = 8;
  localparam bit EDGE = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_in;
  logic [N-1:0] out_onehot;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] pending;
  logic         overflow;

  onehot_req_serializer #(.N(N), .EDGE(EDGE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending set as an integer mask, presented event as an index.
  int m_prev = 0;
  int m_pend = 0;
  int m_ptr  = 0;
  int m_cur  = -1;
  bit m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int rq, input bit rdy, input bit r);
    int  fresh;
    int  take;
    int  rest;
    bit  accepted;
    if (r) begin
      m_prev = 0; m_pend = 0; m_ptr = 0; m_cur = -1; m_ovf = 1'b0;
      return;
    end
    fresh    = EDGE ? (rq & ~m_prev) : rq;
    accepted = (m_cur >= 0) && rdy;
    take     = -1;
    if ((m_cur < 0 || accepted) && m_pend != 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (take < 0 && ((m_pend >> j) & 1) == 1) take = j;
      end
    end
    rest = m_pend;
    if (take >= 0) rest = rest & ~(1 << take);
    m_ovf  = (fresh & rest) != 0;
    m_pend = (rest | fresh) & ((1 << N) - 1);
    if (take >= 0) begin
      m_cur = take;
      m_ptr = (take + 1) % N;
    end else if (accepted) begin
      m_cur = -1;
    end
    m_prev = rq;
  endtask

  task automatic cyc(input logic [N-1:0] rq, input logic rdy, input logic r);
    req_in    = rq;
    out_ready = rdy;
    rst       = r;
    @(posedge clk);
    model_step(int'(rq), rdy, r);
    #1;
    check("valid",    32'(out_valid),  32'(m_cur >= 0));
    check("onehot",   32'(out_onehot), (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0);
    check("pending",  32'(pending),    32'(m_pend));
    check("overflow", 32'(overflow),   32'(m_ovf));
    check("invariant", 32'(out_valid ? $onehot(out_onehot) : (out_onehot == '0)), 32'd1);
  endtask

  initial begin
    req_in = '0; out_ready = 1'b1; rst = 1'b1;

    // Reset state
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    cyc(8'h00, 1'b1, 1'b0);

    // Single event, no repeat while held
    cyc(8'h04, 1'b1, 1'b0);
    check("single_pend", 32'(pending), 32'h04);
    cyc(8'h04, 1'b1, 1'b0);
    check("single_out", 32'(out_onehot), 32'h04);
    cyc(8'h04, 1'b1, 1'b0);
    check("single_done", 32'(out_valid), 32'd0);
    repeat (3) cyc(8'h04, 1'b1, 1'b0);

    // Simultaneous events from rr_ptr=0
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h81, 1'b1, 1'b0);
    cyc(8'h81, 1'b1, 1'b0);
    check("simul_first", 32'(out_onehot), 32'h01);
    cyc(8'h81, 1'b1, 1'b0);
    check("simul_second", 32'(out_onehot), 32'h80);
    cyc(8'h81, 1'b1, 1'b0);
    check("simul_idle", 32'(out_valid), 32'd0);

    // Round-robin wrap after granting bit 3
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h08, 1'b1, 1'b0);
    cyc(8'h08, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h0A, 1'b1, 1'b0);
    cyc(8'h0A, 1'b1, 1'b0);
    check("rr_first", 32'(out_onehot), 32'h02);
    cyc(8'h0A, 1'b1, 1'b0);
    check("rr_second", 32'(out_onehot), 32'h08);
    cyc(8'h00, 1'b1, 1'b0);

    // Backpressure holds the presented event
    cyc(8'h10, 1'b0, 1'b0);
    cyc(8'h10, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      cyc(8'h12, 1'b0, 1'b0);
      check("bp_hold", 32'(out_onehot), 32'h10);
    end
    check("bp_pend", 32'(pending), 32'h02);
    cyc(8'h12, 1'b1, 1'b0);
    check("bp_next", 32'(out_onehot), 32'h02);
    cyc(8'h00, 1'b1, 1'b0);

    // Overflow: second pulse on an already-pending bit
    cyc(8'h01, 1'b0, 1'b0);
    cyc(8'h01, 1'b0, 1'b0);
    cyc(8'h21, 1'b0, 1'b0);
    cyc(8'h01, 1'b0, 1'b0);
    cyc(8'h21, 1'b0, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    cyc(8'h21, 1'b0, 1'b0);
    check("ovf_once", 32'(overflow), 32'd0);
    cyc(8'h21, 1'b1, 1'b0);
    check("ovf_deliver", 32'(out_onehot), 32'h20);
    cyc(8'h21, 1'b1, 1'b0);
    check("ovf_single", 32'(out_valid), 32'd0);

    // Reset mid-operation with a line held through reset
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h02, 1'b0, 1'b0);
    cyc(8'h02, 1'b0, 1'b0);
    cyc(8'h64, 1'b0, 1'b0);
    cyc(8'h66, 1'b0, 1'b0);
    check("mid_pend", 32'(pending), 32'h66);
    check("mid_shown", 32'(out_onehot), 32'h02);
    cyc(8'h40, 1'b0, 1'b1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pend", 32'(pending), 32'd0);
    cyc(8'h40, 1'b1, 1'b0);
    cyc(8'h40, 1'b1, 1'b0);
    check("mid_after", 32'(out_onehot), 32'h40);

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      logic [N-1:0] rq;
      rq = ($urandom_range(0, 3) == 0) ? N'($urandom) : req_in;
      cyc(rq, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
